// File: rtl/move_ctrl.sv
// Grid position controller: edge-detected direction keys steer a cursor that
// advances one cell every TICK_DIV cycles, either stopping at walls or wrapping.
module move_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int TICK_DIV = 25000000,
  parameter int WRAP     = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       L,
  input  logic       U,
  input  logic       R,
  input  logic       D,
  input  logic       en,
  output logic [5:0] px,
  output logic [4:0] py,
  output logic [1:0] dir,
  output logic       step,
  output logic       hit
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TMAX = CW'(TICK_DIV - 1);
  localparam logic [5:0]     XMAX = 6'(GRID_W - 1);
  localparam logic [4:0]     YMAX = 5'(GRID_H - 1);
  localparam logic [5:0]     X0   = 6'(START_X);
  localparam logic [4:0]     Y0   = 5'(START_Y);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    keys, key_q, armed, rise;
  logic          pend_v, take_v, req_v, blocked;
  logic [1:0]    pend_d, take_d, req_d, nd;
  logic [5:0]    nx;
  logic [4:0]    ny;

  // keys packed as {U,D,L,R}; armed blocks keys that were already held at reset
  assign keys = {U, D, L, R};
  assign rise = keys & ~key_q & armed;

  always_comb begin
    req_v = 1'b1;
    req_d = 2'b00;
    if (rise[3])      req_d = 2'b00;
    else if (rise[2]) req_d = 2'b10;
    else if (rise[1]) req_d = 2'b11;
    else if (rise[0]) req_d = 2'b01;
    else              req_v = 1'b0;
  end

  // a non-reversing request overrides any older pending heading
  always_comb begin
    if (req_v && (req_d != (dir ^ 2'b10))) begin
      take_v = 1'b1;
      take_d = req_d;
    end else begin
      take_v = pend_v;
      take_d = pend_d;
    end
    nd = take_v ? take_d : dir;
  end

  always_comb begin
    nx      = px;
    ny      = py;
    blocked = 1'b0;
    case (nd)
      2'b00: if (py == 5'd0) begin ny = YMAX; blocked = (WRAP == 0); end
             else ny = py - 5'd1;
      2'b01: if (px == XMAX) begin nx = 6'd0; blocked = (WRAP == 0); end
             else nx = px + 6'd1;
      2'b10: if (py == YMAX) begin ny = 5'd0; blocked = (WRAP == 0); end
             else ny = py + 5'd1;
      2'b11: if (px == 6'd0) begin nx = XMAX; blocked = (WRAP == 0); end
             else nx = px - 6'd1;
      default: begin nx = px; ny = py; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      px     <= X0;
      py     <= Y0;
      dir    <= 2'b01;
      step   <= 1'b0;
      hit    <= 1'b0;
      cnt    <= '0;
      pend_v <= 1'b0;
      pend_d <= 2'b00;
      key_q  <= 4'b0000;
      armed  <= ~keys;
    end else begin
      key_q <= keys;
      armed <= armed | ~keys;
      step  <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          pend_v <= 1'b0;
          if (req_v) begin
            dir   <= req_d;
            state <= RUN;
          end
        end
        RUN: begin
          if (en && (cnt == TMAX)) begin
            cnt    <= '0;
            pend_v <= 1'b0;
            dir    <= nd;
            if (blocked) begin
              hit   <= 1'b1;
              state <= HALT;
            end else begin
              px   <= nx;
              py   <= ny;
              step <= 1'b1;
            end
          end else begin
            if (en) cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            pend_v <= take_v;
            pend_d <= take_d;
          end
        end
        HALT: begin
          if (req_v) begin
            px     <= X0;
            py     <= Y0;
            dir    <= 2'b01;
            hit    <= 1'b0;
            pend_v <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: a wall-stop and a wrap-around instance share stimulus and
// are checked every cycle against a grid-level reference model plus fixed values.
module tb_move_ctrl;

  localparam int TD = 4;
  localparam int W  = 40;
  localparam int H  = 30;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic kl = 1'b0, ku = 1'b0, kr = 1'b0, kd = 1'b0;
  logic en = 1'b1;
  logic [5:0] px_o [2];
  logic [4:0] py_o [2];
  logic [1:0] dir_o [2];
  logic       step_o [2];
  logic       hit_o [2];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  bit idle_watch = 1'b0;
  int idle_steps = 0;

  always #5 clk = ~clk;

  move_ctrl #(.GRID_W(W), .GRID_H(H), .START_X(20), .START_Y(15), .TICK_DIV(TD), .WRAP(0)) dut0 (
    .clk(clk), .clr(clr), .L(kl), .U(ku), .R(kr), .D(kd), .en(en),
    .px(px_o[0]), .py(py_o[0]), .dir(dir_o[0]), .step(step_o[0]), .hit(hit_o[0]));

  move_ctrl #(.GRID_W(W), .GRID_H(H), .START_X(20), .START_Y(15), .TICK_DIV(TD), .WRAP(1)) dut1 (
    .clk(clk), .clr(clr), .L(kl), .U(ku), .R(kr), .D(kd), .en(en),
    .px(px_o[1]), .py(py_o[1]), .dir(dir_o[1]), .step(step_o[1]), .hit(hit_o[1]));

  // reference model: mode 0 idle, 1 running, 2 halted; headings 0 up,1 right,2 down,3 left
  int m_mode [2], m_x [2], m_y [2], m_d [2], m_cnt [2], m_pd [2];
  bit m_pv [2], m_hit [2], m_step [2];
  bit [3:0] m_kq [2], m_arm [2];

  task automatic model_step(input int i);
    bit [3:0] kv, rise;
    int req, nd, nx, ny;
    kv = {ku, kd, kl, kr};
    if (clr) begin
      m_mode[i] = 0; m_x[i] = 20; m_y[i] = 15; m_d[i] = 1; m_cnt[i] = 0;
      m_pv[i] = 1'b0; m_hit[i] = 1'b0; m_step[i] = 1'b0; m_kq[i] = 4'b0000; m_arm[i] = ~kv;
      return;
    end
    rise = kv & ~m_kq[i] & m_arm[i];
    m_arm[i] = m_arm[i] | ~kv;
    m_kq[i] = kv;
    if (rise[3]) req = 0; else if (rise[2]) req = 2; else if (rise[1]) req = 3;
    else if (rise[0]) req = 1; else req = -1;
    m_step[i] = 1'b0;
    if (m_mode[i] == 0) begin
      if (req >= 0) begin m_d[i] = req; m_mode[i] = 1; m_cnt[i] = 0; m_pv[i] = 1'b0; end
    end else if (m_mode[i] == 1) begin
      if (req >= 0 && req != ((m_d[i] + 2) % 4)) begin m_pv[i] = 1'b1; m_pd[i] = req; end
      if (en) begin
        if (m_cnt[i] == TD - 1) begin
          m_cnt[i] = 0;
          nd = m_pv[i] ? m_pd[i] : m_d[i];
          m_pv[i] = 1'b0;
          m_d[i] = nd;
          nx = m_x[i] + ((nd == 1) ? 1 : (nd == 3) ? -1 : 0);
          ny = m_y[i] + ((nd == 2) ? 1 : (nd == 0) ? -1 : 0);
          if ((nx < 0 || nx >= W || ny < 0 || ny >= H) && i == 0) begin
            m_hit[i] = 1'b1; m_mode[i] = 2;
          end else begin
            m_x[i] = (nx + W) % W; m_y[i] = (ny + H) % H; m_step[i] = 1'b1;
          end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end else begin
      if (req >= 0) begin
        m_x[i] = 20; m_y[i] = 15; m_d[i] = 1; m_hit[i] = 1'b0;
        m_pv[i] = 1'b0; m_cnt[i] = 0; m_mode[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_px%0d", i), int'(px_o[i]), m_x[i]);
        chk($sformatf("model_py%0d", i), int'(py_o[i]), m_y[i]);
        chk($sformatf("model_dir%0d", i), int'(dir_o[i]), m_d[i]);
        chk($sformatf("model_step%0d", i), int'(step_o[i]), int'(m_step[i]));
        chk($sformatf("model_hit%0d", i), int'(hit_o[i]), int'(m_hit[i]));
      end
    end
    if (idle_watch && (step_o[0] || step_o[1])) idle_steps++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(2);
    chk_on = 1'b1;
    clr = 1'b0;
    idle_watch = 1'b1;
    tick(100);
    idle_watch = 1'b0;
    chk("idle_px", int'(px_o[0]), 20);
    chk("idle_py", int'(py_o[0]), 15);
    chk("idle_dir", int'(dir_o[0]), 1);
    chk("idle_hit", int'(hit_o[0]), 0);
    chk("idle_steps", idle_steps, 0);

    ku = 1'b1; tick(1); ku = 1'b0;
    chk("up_dir", int'(dir_o[0]), 0);
    tick(3);
    chk("up_py_before", int'(py_o[0]), 15);
    tick(1);
    chk("up_py_first", int'(py_o[0]), 14);
    chk("up_step_first", int'(step_o[0]), 1);
    tick(4);
    chk("up_py_second", int'(py_o[0]), 13);

    kr = 1'b1; tick(1); kr = 1'b0; tick(3);
    chk("turn_r_dir", int'(dir_o[0]), 1);
    chk("turn_r_px", int'(px_o[0]), 21);
    kl = 1'b1; tick(1); kl = 1'b0; tick(3);
    chk("rev_l_dir", int'(dir_o[0]), 1);
    chk("rev_l_px", int'(px_o[0]), 22);
    kd = 1'b1; tick(1); kd = 1'b0; tick(3);
    chk("turn_d_dir", int'(dir_o[0]), 2);
    chk("turn_d_py", int'(py_o[0]), 14);
    kr = 1'b1; tick(1); kr = 1'b0; tick(3);
    chk("run_r_px", int'(px_o[0]), 23);
    tick(64);
    chk("edge_px", int'(px_o[0]), 39);
    tick(4);
    chk("wall_hit", int'(hit_o[0]), 1);
    chk("wall_px", int'(px_o[0]), 39);
    chk("wrap_px", int'(px_o[1]), 0);
    chk("wrap_hit", int'(hit_o[1]), 0);
    tick(8);
    chk("halt_px", int'(px_o[0]), 39);

    ku = 1'b1; tick(1); ku = 1'b0;
    chk("rel_px", int'(px_o[0]), 20);
    chk("rel_py", int'(py_o[0]), 15);
    chk("rel_hit", int'(hit_o[0]), 0);
    tick(3);
    chk("wrap_up_py", int'(py_o[1]), 13);
    tick(56);
    chk("wrap_top_py", int'(py_o[1]), 29);
    chk("wrap_top_hit", int'(hit_o[1]), 0);

    ku = 1'b1; kl = 1'b1; tick(1); ku = 1'b0; kl = 1'b0;
    chk("prio_dir", int'(dir_o[0]), 0);
    tick(3);
    kd = 1'b1; clr = 1'b1; tick(1);
    chk("clr_px", int'(px_o[0]), 20);
    chk("clr_py", int'(py_o[0]), 15);
    chk("clr_dir", int'(dir_o[0]), 1);
    chk("clr_step", int'(step_o[0]), 0);
    clr = 1'b0; tick(5);
    chk("held_dir", int'(dir_o[0]), 1);
    kd = 1'b0; tick(2); kd = 1'b1; tick(1); kd = 1'b0;
    chk("repress_dir", int'(dir_o[0]), 2);

    en = 1'b0; tick(20);
    chk("pause_py", int'(py_o[0]), 15);
    en = 1'b1; tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
